// File: rtl/subleq_sequencer_if.sv
// subleq_sequencer_if: bundles the host controls, datapath flags, memory
// handshake and status outputs of the SUBLEQ sequencer.
// The master modport is the sequencer side; the slave modport is the
// host/memory/datapath side. Breakpoint signals exist only when
// SUBLEQ_BREAKPOINT_EN is defined.
interface subleq_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              run;
    logic              step;
    logic [DATA_W-1:0] c_addr;
    logic              zero;
    logic              negative;
    logic              mem_ack;
    logic [2:0]        state;
    logic              step_en;
    logic              mem_req;
    logic              mem_we;
    logic              busy;
    logic              halted;
    logic              fault;
    logic [CNT_W-1:0]  instr_count;
`ifdef SUBLEQ_BREAKPOINT_EN
    logic              bp_en;
    logic [DATA_W-1:0] bp_addr;
    logic [DATA_W-1:0] pc;
    logic              bp_hit;

    modport master (
        input  run, step, c_addr, zero, negative, mem_ack, bp_en, bp_addr, pc,
        output state, step_en, mem_req, mem_we, busy, halted, fault, instr_count, bp_hit
    );

    modport slave (
        output run, step, c_addr, zero, negative, mem_ack, bp_en, bp_addr, pc,
        input  state, step_en, mem_req, mem_we, busy, halted, fault, instr_count, bp_hit
    );
`else
    modport master (
        input  run, step, c_addr, zero, negative, mem_ack,
        output state, step_en, mem_req, mem_we, busy, halted, fault, instr_count
    );

    modport slave (
        output run, step, c_addr, zero, negative, mem_ack,
        input  state, step_en, mem_req, mem_we, busy, halted, fault, instr_count
    );
`endif
endinterface

// File: rtl/subleq_sequencer.sv
// subleq_sequencer: owns the SUBLEQ datapath state code (0..7), sequences it
// under run/single-step control, handshakes with the shared memory port with
// a bounded wait, detects halt and counts retired instructions.
// Define SUBLEQ_BREAKPOINT_EN to add a pc breakpoint that parks the sequencer
// in IDLE at an instruction boundary.
module subleq_sequencer #(
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input logic                clk,
    input logic                rst,
    subleq_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_ACTIVE,
        CTRL_HALT,
        CTRL_FAULT
    } ctrl_t;

    localparam logic [2:0] CODE_EXECUTE   = 3'd5;
    localparam logic [2:0] CODE_WRITEBACK = 3'd6;
    localparam logic [2:0] CODE_UPDATE_PC = 3'd7;
    // Last wait-counter value still allowed; one more ack-less cycle faults.
    localparam logic [7:0] WAIT_LAST      = 8'(WAIT_MAX - 1);

    ctrl_t            ctrl_q, ctrl_d;
    logic [2:0]       code_q, code_d;
    logic [7:0]       wait_q, wait_d;
    logic             one_shot_q, one_shot_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             step_en;
    logic             mem_req;
    logic             mem_we;
    logic             is_mem_code;
    logic             start;
    logic             c_neg;
    logic             halt_cond;

`ifdef SUBLEQ_BREAKPOINT_EN
    // first_q: current instruction is the first since leaving IDLE, so the
    // breakpoint is not re-checked. park_q: stopped at a breakpoint with run
    // still high; only a run low->high or a step restarts.
    logic             first_q, first_d;
    logic             park_q, park_d;
    logic             bp_hit_q, bp_hit_d;
`endif

    // A branch target with its sign bit set marks the halt address range.
    assign c_neg       = $signed(bus.c_addr) < $signed({DATA_W{1'b0}});
    assign halt_cond   = (bus.zero | bus.negative) & c_neg;
    assign is_mem_code = (code_q != CODE_EXECUTE) && (code_q != CODE_UPDATE_PC);

`ifdef SUBLEQ_BREAKPOINT_EN
    assign start = bus.step | (bus.run & ~park_q);
`else
    assign start = bus.step | bus.run;
`endif

    assign bus.state       = code_q;
    assign bus.step_en     = step_en;
    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.busy        = (ctrl_q == CTRL_ACTIVE);
    assign bus.halted      = (ctrl_q == CTRL_HALT);
    assign bus.fault       = (ctrl_q == CTRL_FAULT);
    assign bus.instr_count = count_q;
`ifdef SUBLEQ_BREAKPOINT_EN
    assign bus.bp_hit      = bp_hit_q;
`endif

    // Register all controller state; reset wins even mid-instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= CTRL_IDLE;
            code_q     <= 3'd0;
            wait_q     <= 8'd0;
            one_shot_q <= 1'b0;
            count_q    <= '0;
`ifdef SUBLEQ_BREAKPOINT_EN
            first_q    <= 1'b0;
            park_q     <= 1'b0;
            bp_hit_q   <= 1'b0;
`endif
        end else begin
            ctrl_q     <= ctrl_d;
            code_q     <= code_d;
            wait_q     <= wait_d;
            one_shot_q <= one_shot_d;
            count_q    <= count_d;
`ifdef SUBLEQ_BREAKPOINT_EN
            first_q    <= first_d;
            park_q     <= park_d;
            bp_hit_q   <= bp_hit_d;
`endif
        end
    end

    // Next-state and handshake outputs for the IDLE/ACTIVE/HALT/FAULT controller.
    always_comb begin
        ctrl_d     = ctrl_q;
        code_d     = code_q;
        wait_d     = wait_q;
        one_shot_d = one_shot_q;
        count_d    = count_q;
        step_en    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
`ifdef SUBLEQ_BREAKPOINT_EN
        first_d    = first_q;
        park_d     = park_q;
        bp_hit_d   = 1'b0;
`endif

        case (ctrl_q)
            CTRL_IDLE: begin
                code_d = 3'd0;
                wait_d = 8'd0;
`ifdef SUBLEQ_BREAKPOINT_EN
                if (!bus.run) begin
                    park_d = 1'b0;
                end
`endif
                if (start) begin
                    ctrl_d     = CTRL_ACTIVE;
                    one_shot_d = bus.step & ~bus.run;
`ifdef SUBLEQ_BREAKPOINT_EN
                    first_d    = 1'b1;
                    park_d     = 1'b0;
`endif
                end
            end

            CTRL_ACTIVE: begin
                if (is_mem_code) begin
                    mem_req = 1'b1;
                    mem_we  = (code_q == CODE_WRITEBACK);
                    if (bus.mem_ack) begin
                        step_en = 1'b1;
                        code_d  = code_q + 3'd1;
                        wait_d  = 8'd0;
                    end else if (wait_q == WAIT_LAST) begin
                        ctrl_d = CTRL_FAULT;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    step_en = 1'b1;
                    wait_d  = 8'd0;
                    if (code_q == CODE_UPDATE_PC) begin
                        count_d = count_q + CNT_W'(1);
                        code_d  = 3'd0;
`ifdef SUBLEQ_BREAKPOINT_EN
                        first_d = 1'b0;
`endif
                        if (halt_cond) begin
                            ctrl_d = CTRL_HALT;
                        end else if (one_shot_q || !bus.run) begin
                            ctrl_d = CTRL_IDLE;
`ifdef SUBLEQ_BREAKPOINT_EN
                        end else if (!first_q && bus.bp_en && (bus.pc == bus.bp_addr)) begin
                            ctrl_d   = CTRL_IDLE;
                            bp_hit_d = 1'b1;
                            park_d   = 1'b1;
`endif
                        end
                    end else begin
                        code_d = code_q + 3'd1;
                    end
                end
            end

            CTRL_HALT: begin
                code_d = 3'd0;
            end

            default: begin
                // FAULT keeps the faulting code visible for debug.
                code_d = code_q;
            end
        endcase
    end

endmodule

// File: tb/tb_subleq_sequencer.sv
// tb_subleq_sequencer: self-checking bench for subleq_sequencer. A table of
// instruction records drives run-mode execution; per-instruction results are
// queued when stimulus is applied and checked when the DUT retires. Hand
// sequences cover single-step, ack timeout, run drop, mid-instruction reset
// and (with SUBLEQ_BREAKPOINT_EN) the breakpoint.
`timescale 1ns/1ps
module tb_subleq_sequencer;

    localparam int DATA_W   = 16;
    localparam int CNT_W    = 16;
    localparam int WAIT_MAX = 15;

    logic clk = 1'b0;
    logic rst;

    subleq_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

    subleq_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [CNT_W-1:0] count;
        logic             halted;
    } exp_t;

    typedef struct {
        bit               restart;
        logic [DATA_W-1:0] c_addr;
        logic             zero;
        logic             negative;
        int               ack_delay;
        logic [CNT_W-1:0] exp_count;
        logic             exp_halted;
    } vec_t;

    exp_t sb[$];
    bit   pending   = 1'b0;
    int   total     = 0;
    int   bad       = 0;
    int   ack_delay = 0;
    bit   ack_on    = 1'b1;
    int   req_age   = 0;
    bit   proto_on  = 1'b0;
    int   last_state = -1;
    int   hold      = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push_exp(input logic [CNT_W-1:0] count, input logic halted);
        exp_t e;
        e.count  = count;
        e.halted = halted;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.c_addr   = v.c_addr;
        bus.zero     = v.zero;
        bus.negative = v.negative;
        ack_delay    = v.ack_delay;
        push_exp(v.exp_count, v.exp_halted);
    endtask

    // Advance one cycle and sample 1 ns after the falling edge.
    task automatic tick();
        exp_t e;
        bit   is_mem;
        @(negedge clk);
        #1;
        if (pending) begin
            e = sb.pop_front();
            checkOutput("sb_instr_count", bus.instr_count, e.count);
            checkOutput("sb_halted", bus.halted, e.halted);
            pending = 1'b0;
        end
        if (bus.busy !== 1'b1) begin
            checkOutput("inactive_step_en", bus.step_en, 0);
            checkOutput("inactive_mem_req", bus.mem_req, 0);
        end else begin
            if (bus.step_en === 1'b1 && bus.state == 3'd7) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_retire: got retire, want none at %0t", $time);
                end else begin
                    pending = 1'b1;
                end
            end
            if (proto_on) begin
                is_mem = (bus.state != 3'd5) && (bus.state != 3'd7);
                checkOutput("proto_mem_req", bus.mem_req, is_mem);
                checkOutput("proto_mem_we", bus.mem_we, bus.state == 3'd6);
                checkOutput("proto_step_en", bus.step_en, is_mem ? bus.mem_ack : 1'b1);
                if (int'(bus.state) != last_state) begin
                    if (last_state >= 0) begin
                        checkOutput("proto_hold", hold,
                                    (last_state == 5 || last_state == 7) ? 1 : ack_delay + 1);
                    end
                    last_state = int'(bus.state);
                    hold       = 1;
                end else begin
                    hold++;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        tick();
        rst      = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_state"}, bus.state, 0);
        checkOutput({tag, "_step_en"}, bus.step_en, 0);
        checkOutput({tag, "_mem_req"}, bus.mem_req, 0);
        checkOutput({tag, "_mem_we"}, bus.mem_we, 0);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_halted"}, bus.halted, 0);
        checkOutput({tag, "_fault"}, bus.fault, 0);
        checkOutput({tag, "_instr_count"}, bus.instr_count, 0);
    endtask

    task automatic wait_retire(input int limit, input string name);
        int n = 0;
        while ((sb.size() != 0 || pending) && n < limit) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || pending) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got %0d results outstanding, want 0", name, sb.size());
            sb.delete();
            pending = 1'b0;
        end
    endtask

    task automatic wait_state(input logic [2:0] code, input int limit, input string name);
        int n = 0;
        while (!(bus.busy === 1'b1 && bus.state == code) && n < limit) begin
            tick();
            n++;
        end
        checkOutput({name, "_reached"}, bus.state, code);
    endtask

    // Memory responder: acks the current request after ack_delay wait cycles.
    initial begin : mem_model
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1 && ack_on) begin
                if (req_age >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    req_age     = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    req_age++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                req_age     = 0;
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin : main
        vec_t vecs[5];
        vecs[0] = '{1'b1, 16'h0005, 1'b0, 1'b0, 3, 16'd1, 1'b0};
        vecs[1] = '{1'b0, 16'h8000, 1'b0, 1'b0, 1, 16'd2, 1'b0};
        vecs[2] = '{1'b0, 16'hFFFF, 1'b0, 1'b1, 3, 16'd3, 1'b1};
        vecs[3] = '{1'b1, 16'h7FFF, 1'b1, 1'b1, 1, 16'd1, 1'b0};
        vecs[4] = '{1'b0, 16'h8000, 1'b1, 1'b0, 2, 16'd2, 1'b1};

        bus.run      = 1'b0;
        bus.step     = 1'b0;
        bus.c_addr   = '0;
        bus.zero     = 1'b0;
        bus.negative = 1'b0;
`ifdef SUBLEQ_BREAKPOINT_EN
        bus.bp_en    = 1'b0;
        bus.bp_addr  = '0;
        bus.pc       = '0;
`endif

        $display("[TB] reset");
        do_reset();
        check_reset_values("reset");

        $display("[TB] single step, zero-wait memory");
        bus.c_addr = 16'h0005;
        ack_delay  = 0;
        push_exp(16'd1, 1'b0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput("step_state", bus.state, k);
            checkOutput("step_step_en", bus.step_en, 1);
            checkOutput("step_busy", bus.busy, 1);
            tick();
        end
        checkOutput("step_done_busy", bus.busy, 0);
        checkOutput("step_done_state", bus.state, 0);
        tick();
        checkOutput("step_stays_idle", bus.busy, 0);

        $display("[TB] run-mode instruction table");
        proto_on   = 1'b1;
        last_state = -1;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].restart) begin
                do_reset();
                bus.run = 1'b1;
            end
            applyStimulus(vecs[i]);
            wait_retire(400, "table");
        end
        proto_on = 1'b0;

        $display("[TB] halt is sticky");
        bus.step = 1'b1;
        bus.run  = 1'b1;
        tick();
        bus.step = 1'b0;
        tick();
        tick();
        checkOutput("halt_sticky", bus.halted, 1);
        checkOutput("halt_busy", bus.busy, 0);
        checkOutput("halt_state", bus.state, 0);
        checkOutput("halt_count", bus.instr_count, 2);

        $display("[TB] ack on last allowed wait cycle");
        do_reset();
        ack_delay = WAIT_MAX - 1;
        bus.run   = 1'b1;
        for (int i = 0; i < WAIT_MAX; i++) begin
            tick();
        end
        checkOutput("ackwin_step_en", bus.step_en, 1);
        tick();
        checkOutput("ackwin_state", bus.state, 1);
        checkOutput("ackwin_fault", bus.fault, 0);

        $display("[TB] ack timeout");
        do_reset();
        ack_on  = 1'b0;
        bus.run = 1'b1;
        for (int i = 0; i < WAIT_MAX; i++) begin
            tick();
            checkOutput("timeout_wait_req", bus.mem_req, 1);
            checkOutput("timeout_wait_fault", bus.fault, 0);
        end
        tick();
        checkOutput("timeout_fault", bus.fault, 1);
        checkOutput("timeout_mem_req", bus.mem_req, 0);
        checkOutput("timeout_state", bus.state, 0);
        checkOutput("timeout_busy", bus.busy, 0);
        ack_on   = 1'b1;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        tick();
        checkOutput("timeout_fault_sticky", bus.fault, 1);
        checkOutput("timeout_state_frozen", bus.state, 0);

        $display("[TB] run dropped mid-instruction");
        do_reset();
        checkOutput("reset_clears_fault", bus.fault, 0);
        ack_delay  = 0;
        bus.c_addr = 16'h0005;
        bus.zero   = 1'b0;
        bus.negative = 1'b0;
        bus.run    = 1'b1;
        push_exp(16'd1, 1'b0);
        wait_state(3'd3, 50, "rundrop");
        bus.run = 1'b0;
        wait_retire(50, "rundrop");
        checkOutput("rundrop_busy", bus.busy, 0);
        checkOutput("rundrop_state", bus.state, 0);
        tick();
        checkOutput("rundrop_stays_idle", bus.busy, 0);

        $display("[TB] reset during writeback");
        bus.run = 1'b1;
        wait_state(3'd6, 50, "midrst");
        checkOutput("midrst_mem_we", bus.mem_we, 1);
        do_reset();
        check_reset_values("midrst");

`ifdef SUBLEQ_BREAKPOINT_EN
        $display("[TB] breakpoint");
        ack_delay   = 0;
        bus.bp_en   = 1'b1;
        bus.bp_addr = 16'h0006;
        bus.pc      = 16'h0006;
        bus.c_addr  = 16'h0005;
        bus.run     = 1'b1;
        push_exp(16'd1, 1'b0);
        push_exp(16'd2, 1'b0);
        wait_retire(100, "bp");
        checkOutput("bp_hit_pulse", bus.bp_hit, 1);
        checkOutput("bp_idle", bus.busy, 0);
        tick();
        checkOutput("bp_hit_clear", bus.bp_hit, 0);
        checkOutput("bp_parked", bus.busy, 0);
        bus.run = 1'b0;
        tick();
        push_exp(16'd3, 1'b0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        wait_retire(50, "bp_step");
        checkOutput("bp_step_no_hit", bus.bp_hit, 0);
        checkOutput("bp_step_idle", bus.busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
